key_event_scheduler: RTL and testbench

Sequencer and buffer between the 8-key debounced keyboard controller and any downstream byte consumer (display, UART, game logic). Generates the scan/sample tick that paces the controller's debounce sampling. Queues each new-byte event (`keyReady` + byte) in a small FIFO and releases bytes one at a time over a valid/ready handshake, with a programmable inter-byte gap.

---
 rtl/bytetype_pkg.sv | 12 +
 rtl/byte_fifo.sv | 61 ++++++
 rtl/key_event_scheduler.sv | 157 +++++++++++++++
 tb/tb_key_event_scheduler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bytetype_pkg.sv
// Shared byte type and output-sequencer state encoding for the key event path.
package bytetype_pkg;

    typedef logic [7:0] myByte_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } sched_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide circular FIFO with a combinational head read and an occupancy count.
// The caller guarantees pop only when not empty; the accept-when-full-with-pop
// decision is made by the parent, so push here is always honoured.
module byte_fifo
    import bytetype_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       push,
    input  logic                       pop,
    input  myByte_t                    din,
    output myByte_t                    dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    myByte_t            mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;

    // Storage write; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - CNT_W'(1);
            end
        end
    end

    assign dout  = mem[rd_ptr_reg];
    assign count = count_reg;
    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);

endmodule

// File: rtl/key_event_scheduler.sv
// Paces keyboard debounce sampling with a scan tick, queues key bytes and
// releases them one at a time over valid/ready with an idle gap after each.
module key_event_scheduler
    import bytetype_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int TICK_DIV   = 1000,
    parameter int GAP_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       RST,
    input  logic                       enable,
    output logic                       scan_tick,
    input  logic                       key_ready,
    input  logic [7:0]                 key_byte,
    output logic                       out_valid,
    output logic [7:0]                 out_byte,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    input  logic                       clear_overflow
);

    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int SCAN_W = $clog2(TICK_DIV);
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(TICK_DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD  = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    logic [SCAN_W-1:0] scan_cnt_reg;
    logic              scan_tick_reg;

    sched_state_t      state_reg;
    sched_state_t      state_next;
    logic [GAP_W-1:0]  gap_cnt_reg;
    logic [GAP_W-1:0]  gap_cnt_next;

    myByte_t           out_byte_reg;
    logic              overflow_reg;

    logic              capture;
    logic              push;
    logic              pop;
    logic              drop;

    myByte_t           fifo_dout;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    // A full FIFO still accepts a byte when the sequencer frees a slot in the same cycle.
    assign capture = key_ready && enable;
    assign push    = capture && (!fifo_full || pop);
    assign drop    = capture && fifo_full && !pop;

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .srst  (RST),
        .push  (push),
        .pop   (pop),
        .din   (key_byte),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Free-running scan divider that freezes while disabled; tick follows the terminal count.
    always_ff @(posedge clk) begin
        if (RST) begin
            scan_cnt_reg  <= '0;
            scan_tick_reg <= 1'b0;
        end else begin
            scan_tick_reg <= enable && (scan_cnt_reg == SCAN_LAST);
            if (enable) begin
                scan_cnt_reg <= (scan_cnt_reg == SCAN_LAST) ? '0 : scan_cnt_reg + SCAN_W'(1);
            end
        end
    end

    // Output sequencer state and gap counter registers.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_reg   <= IDLE;
            gap_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            gap_cnt_reg <= gap_cnt_next;
        end
    end

    // Sequencer next state: pop into the output register, hold until accepted, then idle out the gap.
    always_comb begin
        state_next   = state_reg;
        gap_cnt_next = gap_cnt_reg;
        pop          = 1'b0;
        out_valid    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (GAP_CYCLES == 0) begin
                        state_next = IDLE;
                    end else begin
                        state_next   = GAP;
                        gap_cnt_next = GAP_LOAD;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg - GAP_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output byte is loaded only on a pop so it stays stable through SEND and afterwards.
    always_ff @(posedge clk) begin
        if (RST) begin
            out_byte_reg <= '0;
        end else if (pop) begin
            out_byte_reg <= fifo_dout;
        end
    end

    // Sticky drop flag; a new drop takes priority over a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (RST) begin
            overflow_reg <= 1'b0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
        end else if (clear_overflow) begin
            overflow_reg <= 1'b0;
        end
    end

    assign scan_tick = scan_tick_reg;
    assign out_byte  = out_byte_reg;
    assign count     = fifo_count;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_key_event_scheduler.sv
// Directed bench for key_event_scheduler with default parameters.
module tb_key_event_scheduler;

    logic       clk;
    logic       RST;
    logic       enable;
    logic       scan_tick;
    logic       key_ready;
    logic [7:0] key_byte;
    logic       out_valid;
    logic [7:0] out_byte;
    logic       out_ready;
    logic [3:0] count;
    logic       overflow;
    logic       clear_overflow;

    int n_checks  = 0;
    int n_fail    = 0;
    int model_cnt = 0;

    key_event_scheduler #(
        .DEPTH      (8),
        .TICK_DIV   (1000),
        .GAP_CYCLES (4)
    ) dut (
        .clk            (clk),
        .RST            (RST),
        .enable         (enable),
        .scan_tick      (scan_tick),
        .key_ready      (key_ready),
        .key_byte       (key_byte),
        .out_valid      (out_valid),
        .out_byte       (out_byte),
        .out_ready      (out_ready),
        .count          (count),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
        $display("check %-18s observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance one cycle; tracks the scan divider value the current cycle should hold.
    task automatic tick();
        if (RST) begin
            model_cnt = 0;
        end else if (enable) begin
            model_cnt = (model_cnt == 999) ? 0 : model_cnt + 1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         first_tick;
        int         second_tick;
        int         highs;
        int         bad;
        int         got_n;
        int         stray;
        int         h;
        int         k;
        logic [7:0] got [16];
        logic [7:0] exp_drain [9];

        exp_drain = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0C};

        // Reset
        RST            = 1'b1;
        enable         = 1'b0;
        key_ready      = 1'b0;
        key_byte       = 8'h00;
        out_ready      = 1'b0;
        clear_overflow = 1'b0;
        repeat (3) tick();
        check("rst_scan_tick", 32'(scan_tick), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_byte",  32'(out_byte),  32'd0);
        check("rst_count",     32'(count),     32'd0);
        check("rst_overflow",  32'(overflow),  32'd0);

        // Scan tick period: first pulse in cycle 1000, next in cycle 2000, one cycle wide
        RST         = 1'b0;
        enable      = 1'b1;
        first_tick  = -1;
        second_tick = -1;
        highs       = 0;
        bad         = 0;
        for (int c = 0; c <= 2005; c++) begin
            if (scan_tick === 1'b1) begin
                highs++;
                if (first_tick < 0) first_tick = c;
                else if (second_tick < 0) second_tick = c;
            end
            if (first_tick < 0 && (out_valid !== 1'b0 || out_byte !== 8'h00 ||
                                   count !== 4'd0 || overflow !== 1'b0)) begin
                bad = 1;
            end
            tick();
        end
        check("scan_first",   32'(first_tick),  32'd1000);
        check("scan_second",  32'(second_tick), 32'd2000);
        check("scan_highs",   32'(highs),       32'd2);
        check("idle_outputs", 32'(bad),         32'd0);

        // Single event with a second byte queued behind it
        out_ready = 1'b1;
        key_byte  = 8'h41;
        key_ready = 1'b1;
        tick();                                   // N+1
        key_ready = 1'b0;
        check("ev_count_n1", 32'(count),     32'd1);
        check("ev_valid_n1", 32'(out_valid), 32'd0);
        tick();                                   // N+2
        check("ev_valid_n2", 32'(out_valid), 32'd1);
        check("ev_byte_n2",  32'(out_byte),  32'h41);
        check("ev_count_n2", 32'(count),     32'd0);
        key_byte  = 8'h42;
        key_ready = 1'b1;
        tick();                                   // N+3
        key_ready = 1'b0;
        check("ev_valid_n3", 32'(out_valid), 32'd0);
        check("ev_count_n3", 32'(count),     32'd1);
        repeat (4) tick();                        // N+7
        check("ev_valid_n7", 32'(out_valid), 32'd0);
        tick();                                   // N+8
        check("ev_valid_n8", 32'(out_valid), 32'd1);
        check("ev_byte_n8",  32'(out_byte),  32'h42);
        repeat (8) tick();
        out_ready = 1'b0;

        // Fill with consumer stalled: 0x01 held, 0x02..0x09 queued, 0x0A dropped
        for (int i = 0; i < 10; i++) begin
            key_byte  = 8'(i + 1);
            key_ready = 1'b1;
            tick();
            if (i == 8) begin
                check("fill_count_at_9",  32'(count),    32'd8);
                check("fill_ovf_before",  32'(overflow), 32'd0);
            end
        end
        key_ready = 1'b0;
        check("fill_count", 32'(count),     32'd8);
        check("fill_ovf",   32'(overflow),  32'd1);
        check("fill_valid", 32'(out_valid), 32'd1);
        check("fill_byte",  32'(out_byte),  32'h01);

        // Accept 0x01, drop with clear in the same cycle, clear, then push coincident with pop
        out_ready = 1'b1;
        tick();                                   // A+1 (GAP)
        out_ready      = 1'b0;
        check("gap_valid", 32'(out_valid), 32'd0);
        key_byte       = 8'h0B;
        key_ready      = 1'b1;
        clear_overflow = 1'b1;
        tick();                                   // A+2
        key_ready      = 1'b0;
        clear_overflow = 1'b0;
        check("ovf_set_wins",   32'(overflow), 32'd1);
        check("drop_count",     32'(count),    32'd8);
        clear_overflow = 1'b1;
        tick();                                   // A+3
        clear_overflow = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);
        repeat (2) tick();                        // A+5 (IDLE, pops now)
        check("pre_pop_valid", 32'(out_valid), 32'd0);
        check("pre_pop_count", 32'(count),     32'd8);
        key_byte  = 8'h0C;
        key_ready = 1'b1;
        tick();                                   // A+6
        key_ready = 1'b0;
        check("pushpop_count", 32'(count),     32'd8);
        check("pushpop_ovf",   32'(overflow),  32'd0);
        check("pushpop_valid", 32'(out_valid), 32'd1);
        check("pushpop_byte",  32'(out_byte),  32'h02);

        // Disable: key strobes ignored, scan tick stops, queue drains
        enable    = 1'b0;
        out_ready = 1'b1;
        got_n     = 0;
        stray     = 0;
        for (int c = 0; c < 80; c++) begin
            key_ready = (c % 3 == 0);
            key_byte  = 8'hEE;
            if (out_valid === 1'b1 && got_n < 16) begin
                got[got_n] = out_byte;
                got_n++;
            end
            if (c > 0 && scan_tick !== 1'b0) stray++;
            tick();
        end
        key_ready = 1'b0;
        check("drain_n", 32'(got_n), 32'd9);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("drain_byte_%0d", i), 32'(got[i]), 32'(exp_drain[i]));
        end
        check("drain_count",     32'(count),    32'd0);
        check("drain_ovf",       32'(overflow), 32'd0);
        check("disabled_ticks",  32'(stray),    32'd0);

        // Re-enable: next pulse comes 1000-h cycles later, h being the held divider value
        h      = model_cnt;
        enable = 1'b1;
        k      = -1;
        for (int c = 0; c < 1100; c++) begin
            if (scan_tick === 1'b1) begin
                k = c;
                break;
            end
            tick();
        end
        check("resume_tick", 32'(k), 32'(1000 - h));

        // Reset during SEND with three bytes queued
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            key_byte  = 8'(8'h10 + i);
            key_ready = 1'b1;
            tick();
        end
        key_ready = 1'b0;
        check("pre_rst_count", 32'(count),     32'd3);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_byte",  32'(out_byte),  32'h10);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("post_rst_valid", 32'(out_valid), 32'd0);
        check("post_rst_count", 32'(count),     32'd0);
        check("post_rst_ovf",   32'(overflow),  32'd0);
        check("post_rst_byte",  32'(out_byte),  32'd0);
        repeat (4) tick();
        check("post_rst_idle",  32'(out_valid), 32'd0);
        key_byte  = 8'h55;
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        tick();
        check("post_rst_valid2", 32'(out_valid), 32'd1);
        check("post_rst_byte2",  32'(out_byte),  32'h55);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
